demux2_pipe: RTL and testbench
==============================

Name: demux2_pipe

Overview:
- Registered 1-to-2 demultiplexer: the inverse of the datapath 2:1 select mux.
- Steers a single valid/ready producer stream to one of two consumers, chosen per transfer by `in_sel`.
- Each output has a 2-entry buffer, so full throughput is kept with no combinational ready path from output to input.
- Used between pipeline stages where one result must be routed to one of two destinations (e.g. writeback vs. memory path).
- Keeps per-output delivered-transfer counters for debug.

Parameters:
- WIDTH, 32, data width in bits of `in_data`, `out0_data` and `out1_data`.
- CNTW, 16, width of each delivered-transfer counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer has a word
- in_ready  output  1  block accepts the word this cycle
- in_data  input  WIDTH  producer word
- in_sel  input  1  destination: 0 = out0, 1 = out1; sampled with `in_data`
- out0_valid  output  1  out0 buffer non-empty
- out0_ready  input  1  consumer 0 takes the head word
- out0_data  output  WIDTH  out0 head word
- out1_valid  output  1  out1 buffer non-empty
- out1_ready  input  1  consumer 1 takes the head word
- out1_data  output  WIDTH  out1 head word
- cnt0  output  CNTW  number of words delivered on out0
- cnt1  output  CNTW  number of words delivered on out1

Behaviour:
- Reset (asynchronous, `rst_n` = 0):
  - Both buffers empty (occupancy 0); `out0_valid` = `out1_valid` = 0.
  - `out0_data` = `out1_data` = 0; `cnt0` = `cnt1` = 0.
  - Any buffered words are discarded.
  - The first accept can happen on the first rising edge after `rst_n` deasserts.
- Each output channel k is a 2-entry FIFO with occupancy `occ_k` in {0,1,2}.
  - Per-channel state: EMPTY (0), ONE (1), FULL (2).
- Ready and transfer rules:
  - `in_ready` = (`occ_sel` != 2), where `occ_sel` is the occupancy of the channel named by `in_sel`.
  - `in_ready` depends only on `in_sel` and registered occupancy, never on `out*_ready`.
  - Accept (push) = `in_valid` && `in_ready`; the word goes to the channel named by `in_sel`.
  - Pop on channel k = `outk_valid` && `outk_ready`.
  - `outk_valid` = (`occ_k` != 0); `outk_data` = head entry, driven from a register.
- Latency: a word accepted in cycle N is visible on `outk_valid`/`outk_data` in cycle N+1. Minimum latency is 1 and there is no bypass.
- Ordering: per channel, words leave in acceptance order. There is no ordering guarantee between channels.
- Occupancy transitions per channel:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop in the same cycle: unchanged. The head advances; the new word enters at the tail.
  - In EMPTY, push and pop cannot coincide, because valid is 0.
  - In FULL, no push is possible, because `in_ready` is 0 for that channel.
- A full channel blocks only transfers addressed to it. A word for the other channel is accepted in the same cycle.
- `out*_ready` asserted while the channel is empty has no effect.
- The data registers hold their value when not written; contents while valid = 0 are don't-care apart from the reset value.
- Counters:
  - `cntk` increments by 1 on each pop of channel k.
  - They wrap modulo 2^CNTW (0xFFFF → 0x0000 for CNTW = 16).
  - Counters are not saturating and there is no clear other than reset.
- `in_data` and `in_sel` are ignored when `in_valid` = 0.

Test Plan:
- **Reset:** assert `rst_n` = 0 mid-stream with both buffers FULL → next sample shows both valids 0, both data 0, cnt0 = cnt1 = 0; after deassert, pushing 0xA5A5A5A5 with sel 0 → `out0_valid` = 1 next cycle with data 0xA5A5A5A5.
- **Throughput:** stream 0x1, 0x2, 0x3, 0x4 with sel 0 and `out0_ready` held 1 → one accept per cycle, out0 emits 1, 2, 3, 4 on consecutive cycles starting one cycle after the first accept; cnt0 = 4, cnt1 = 0.
- **Backpressure:** `out0_ready` = 0; push 0x10, 0x11, then offer 0x12 with sel 0 → `in_ready` = 0 on the third offer; same cycle with `in_sel` = 1 and data 0x20 → accepted, and `out1_data` = 0x20 next cycle; release `out0_ready` → out0 emits 0x10, 0x11, then 0x12.
- **Simultaneous push/pop in ONE:** out1 holds 0x30 with `out1_ready` = 1; push 0x31 with sel 1 in the same cycle → occupancy stays 1, and the next cycle's `out1_data` = 0x31.
- **Alternating select:** sel pattern 0, 1, 0, 1 with data 0xB0..0xB3 and both readies 1 → out0 gets 0xB0, 0xB2 and out1 gets 0xB1, 0xB3; cnt0 = cnt1 = 2.
- **Counter wrap:** preload by delivering 65535 words on out1, then one more → cnt1 goes 0xFFFF → 0x0000, and cnt0 is unchanged.

Source files
------------

// File: rtl/demux2_pipe.sv
// Registered 1-to-2 demultiplexer: steers one valid/ready stream to out0 or out1
// (chosen per word by in_sel), each output backed by a 2-entry FIFO and a delivered-word counter.
module demux2_pipe #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNTW-1:0]  cnt0,
  output logic [CNTW-1:0]  cnt1
);

  // Handshake: a word moves on any interface in a cycle where its valid and ready are
  // both 1 at the rising edge. valid never waits on ready; in_ready looks only at in_sel
  // and registered occupancy, so there is no combinational path from out*_ready.

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_e;

  // Per-channel occupancy FSM; index 0 is out0, index 1 is out1.
  occ_state_e       state   [2];
  logic [WIDTH-1:0] head_q  [2];
  logic [WIDTH-1:0] tail_q  [2];
  logic             valid_q [2];
  logic [CNTW-1:0]  cnt_q   [2];

  logic [1:0] out_ready;
  logic [1:0] push;
  logic [1:0] pop;

  assign out_ready = {out1_ready, out0_ready};
  assign in_ready  = (state[in_sel] != FULL);

  always_comb begin
    push = 2'b00;
    pop  = 2'b00;
    if (in_valid && in_ready) begin
      push[in_sel] = 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      pop[k] = valid_q[k] & out_ready[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        state[k]   <= EMPTY;
        head_q[k]  <= '0;
        tail_q[k]  <= '0;
        valid_q[k] <= 1'b0;
        cnt_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        case (state[k])
          EMPTY: begin
            if (push[k]) begin
              head_q[k]  <= in_data;
              state[k]   <= ONE;
              valid_q[k] <= 1'b1;
            end
          end
          ONE: begin
            case ({push[k], pop[k]})
              2'b10: begin
                tail_q[k] <= in_data;
                state[k]  <= FULL;
              end
              2'b01: begin
                state[k]   <= EMPTY;
                valid_q[k] <= 1'b0;
              end
              // Head leaves while the new word takes its place; occupancy stays 1.
              2'b11: head_q[k] <= in_data;
              default: ;
            endcase
          end
          FULL: begin
            if (pop[k]) begin
              head_q[k] <= tail_q[k];
              state[k]  <= ONE;
            end
          end
          default: begin
            state[k]   <= EMPTY;
            valid_q[k] <= 1'b0;
          end
        endcase
        if (pop[k]) begin
          cnt_q[k] <= cnt_q[k] + CNTW'(1);
        end
      end
    end
  end

  assign out0_valid = valid_q[0];
  assign out0_data  = head_q[0];
  assign out1_valid = valid_q[1];
  assign out1_data  = head_q[1];
  assign cnt0       = cnt_q[0];
  assign cnt1       = cnt_q[1];

endmodule

// File: tb/tb_demux2_pipe.sv
// Self-checking bench for demux2_pipe: directed scenarios plus random traffic, all
// compared each cycle against a queue-based reference of the two output FIFOs.
module tb_demux2_pipe;
  localparam int WIDTH = 32;
  localparam int CNTW  = 16;
  localparam int CMOD  = 2 ** CNTW;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic [CNTW-1:0]  cnt0;
  logic [CNTW-1:0]  cnt1;

  demux2_pipe #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  logic [WIDTH-1:0] exp_q0[$];
  logic [WIDTH-1:0] exp_q1[$];
  int exp_c0;
  int exp_c1;
  int err_cnt;
  int chk_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    check("out0_valid", 64'(out0_valid), 64'(exp_q0.size() != 0));
    check("out1_valid", 64'(out1_valid), 64'(exp_q1.size() != 0));
    if (exp_q0.size() != 0) check("out0_data", 64'(out0_data), 64'(exp_q0[0]));
    if (exp_q1.size() != 0) check("out1_data", 64'(out1_data), 64'(exp_q1[0]));
    check("cnt0", 64'(cnt0), 64'(exp_c0));
    check("cnt1", 64'(cnt1), 64'(exp_c1));
  endtask

  // ---------------- driver ----------------
  // One clock of traffic: check state from the previous edge, drive, then advance the model.
  task automatic cycle(input logic v, input logic s, input logic [WIDTH-1:0] d,
                       input logic r0, input logic r1, output logic acc);
    logic exp_rdy;
    @(negedge clk);
    compare_outputs();
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    #1;
    exp_rdy = s ? (exp_q1.size() < 2) : (exp_q0.size() < 2);
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (r0 && exp_q0.size() != 0) begin
      void'(exp_q0.pop_front());
      exp_c0 = (exp_c0 + 1) % CMOD;
    end
    if (r1 && exp_q1.size() != 0) begin
      void'(exp_q1.pop_front());
      exp_c1 = (exp_c1 + 1) % CMOD;
    end
    acc = v && exp_rdy;
    if (acc) begin
      if (s) exp_q1.push_back(d);
      else   exp_q0.push_back(d);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = '0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    #1;
    check("rst_out0_valid", 64'(out0_valid), 64'd0);
    check("rst_out1_valid", 64'(out1_valid), 64'd0);
    check("rst_out0_data",  64'(out0_data),  64'd0);
    check("rst_out1_data",  64'(out1_data),  64'd0);
    check("rst_cnt0",       64'(cnt0),       64'd0);
    check("rst_cnt1",       64'(cnt1),       64'd0);
    exp_q0.delete();
    exp_q1.delete();
    exp_c0 = 0;
    exp_c1 = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n, input logic r0, input logic r1);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, r0, r1, acc);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic acc;
    int   c0_before;
    int   budget;
    logic saw_max;
    err_cnt    = 0;
    chk_cnt    = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = '0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    do_reset();

    // First word after reset, visible one cycle later.
    cycle(1'b1, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0, acc);
    check("first_accept", 64'(acc), 64'd1);
    idle(1, 1'b1, 1'b0);
    idle(2, 1'b1, 1'b1);

    // Throughput on out0 with ready held high.
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 1'b0, WIDTH'(i), 1'b1, 1'b0, acc);
      check("tput_accept", 64'(acc), 64'd1);
    end
    idle(3, 1'b1, 1'b0);

    // Backpressure on out0; out1 still accepts.
    cycle(1'b1, 1'b0, 32'h10, 1'b0, 1'b0, acc);
    cycle(1'b1, 1'b0, 32'h11, 1'b0, 1'b0, acc);
    cycle(1'b1, 1'b0, 32'h12, 1'b0, 1'b0, acc);
    check("bp_blocked", 64'(acc), 64'd0);
    cycle(1'b1, 1'b1, 32'h20, 1'b0, 1'b0, acc);
    check("bp_other_accept", 64'(acc), 64'd1);
    budget = 0;
    do begin
      cycle(1'b1, 1'b0, 32'h12, 1'b1, 1'b0, acc);
      budget++;
    end while (!acc && budget < 8);
    check("bp_retry_accept", 64'(acc), 64'd1);
    idle(4, 1'b1, 1'b1);

    // Push and pop together while out1 holds one word.
    cycle(1'b1, 1'b1, 32'h30, 1'b0, 1'b0, acc);
    cycle(1'b1, 1'b1, 32'h31, 1'b0, 1'b1, acc);
    idle(1, 1'b0, 1'b0);
    check("pp_out1_data", 64'(out1_data), 64'h31);
    idle(2, 1'b0, 1'b1);

    // Alternating select, both consumers ready.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'(i % 2), WIDTH'(32'hB0 + i), 1'b1, 1'b1, acc);
    idle(3, 1'b1, 1'b1);

    // Fill both channels, then reset mid-stream.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'(i / 2), WIDTH'(32'hC0 + i), 1'b0, 1'b0, acc);
    idle(1, 1'b0, 1'b0);
    check("full_blocks_0", 64'(exp_q0.size()), 64'd2);
    do_reset();
    cycle(1'b1, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0, acc);
    idle(2, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), WIDTH'($urandom()),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), acc);
    end
    idle(4, 1'b1, 1'b1);

    // Counter wrap on out1 from a fresh reset.
    do_reset();
    c0_before = exp_c0;
    saw_max   = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      cycle(1'b1, 1'b1, WIDTH'(i), 1'b0, 1'b1, acc);
      if (exp_c1 == CMOD - 1) saw_max = 1'b1;
      if (saw_max && exp_c1 == 0) break;
    end
    idle(1, 1'b0, 1'b0);
    check("cnt1_wrap", 64'(cnt1), 64'd0);
    check("cnt0_unchanged", 64'(cnt0), 64'(c0_before));

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  // Watchdog: the run above is bounded, this only guards against a stuck simulator.
  initial begin
    #2000000;
    err_cnt++;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $fatal(1);
  end

endmodule
